// File: rtl/jk_pkg.sv
// Shared definitions for the JK counter/register family.
//   - Mode encodings for jk_counter_register.
//   - jk_next: next-state of one JK flip-flop for a given (q, j, k).
package jk_pkg;

    localparam logic [1:0] MODE_JK   = 2'd0;
    localparam logic [1:0] MODE_UP   = 2'd1;
    localparam logic [1:0] MODE_DOWN = 2'd2;
    localparam logic [1:0] MODE_LOAD = 2'd3;

    // JK truth table: 00 hold, 01 clear, 10 set, 11 toggle.
    function automatic logic jk_next(input logic q, input logic j, input logic k);
        logic r;
        case ({j, k})
            2'b00:   r = q;
            2'b01:   r = 1'b0;
            2'b10:   r = 1'b1;
            2'b11:   r = ~q;
            default: r = q;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/jk_next_state.sv
// Combinational next-state cell for one JK flip-flop bit.
// Ports:
//   q       current bit state
//   j, k    JK inputs for this bit
//   q_next  value the bit takes on the next enabled edge in JK mode
module jk_next_state
    import jk_pkg::*;
(
    input  logic q,
    input  logic j,
    input  logic k,
    output logic q_next
);

    // Per-bit JK next state.
    always_comb begin
        q_next = jk_next(q, j, k);
    end

endmodule

// File: rtl/jk_counter_register.sv
// WIDTH-bit bank of JK flip-flops with modulo up/down counting and a
// clamped parallel load, all sharing one clock.
// Ports:
//   input_clock1_c_1  rising-edge clock
//   input_reset_2     asynchronous active-high reset (q <= RESET_VALUE)
//   en                clock enable, 0 holds q
//   mode              0 JK, 1 count up, 2 count down, 3 load
//   j, k              per-bit JK inputs (mode 0)
//   load_data         parallel load value (mode 3), clamped to MODULUS-1
//   q, q_n            state and its bitwise complement
//   terminal          combinational terminal-count flag for the current mode
//   wrap_pulse        one-cycle pulse after an up 9->0 / down 0->9 style wrap
module jk_counter_register
    import jk_pkg::*;
#(
    parameter int unsigned      WIDTH       = 4,
    parameter longint unsigned  MODULUS     = (64'd1 << WIDTH),
    parameter longint unsigned  RESET_VALUE = 64'd0
) (
    input  logic             input_clock1_c_1,
    input  logic             input_reset_2,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n,
    output logic             terminal,
    output logic             wrap_pulse
);

    // Bad parameter sets are rejected at elaboration.
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $fatal(1, "jk_counter_register: WIDTH must be 1..32");
    end
    if (MODULUS < 64'd2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
        $fatal(1, "jk_counter_register: MODULUS must be 2..2**WIDTH");
    end
    if (RESET_VALUE >= MODULUS) begin : g_bad_reset
        $fatal(1, "jk_counter_register: RESET_VALUE must be < MODULUS");
    end

    // Counter arithmetic is one bit wider so MODULUS == 2**WIDTH is representable.
    localparam logic [WIDTH:0]   MOD_W   = MODULUS[WIDTH:0];
    localparam logic [WIDTH:0]   MAX_W   = MOD_W - {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MAX_Q   = MAX_W[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RESET_Q = RESET_VALUE[WIDTH-1:0];

    logic [WIDTH-1:0] q_r;
    logic             wrap_r;
    logic [WIDTH-1:0] jk_q_s;
    logic [WIDTH:0]   q_ext_s;
    logic [WIDTH:0]   inc_s;
    logic [WIDTH:0]   dec_s;
    logic [WIDTH:0]   ld_ext_s;
    logic [WIDTH-1:0] next_q_s;
    logic             next_wrap_s;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_jk_bit
        jk_next_state u_jk_next_state (
            .q      (q_r[gi]),
            .j      (j[gi]),
            .k      (k[gi]),
            .q_next (jk_q_s[gi])
        );
    end

    assign q_ext_s  = {1'b0, q_r};
    assign ld_ext_s = {1'b0, load_data};
    assign inc_s    = q_ext_s + {{WIDTH{1'b0}}, 1'b1};
    assign dec_s    = q_ext_s - {{WIDTH{1'b0}}, 1'b1};

    // Next-state selection for all four modes; en=0 holds q and clears the pulse.
    always_comb begin
        next_q_s    = q_r;
        next_wrap_s = 1'b0;
        if (en) begin
            case (mode)
                MODE_JK: begin
                    next_q_s = jk_q_s;
                end
                MODE_UP: begin
                    // >= rather than == so out-of-range JK results also wrap to 0.
                    if (q_ext_s >= MAX_W) begin
                        next_q_s    = {WIDTH{1'b0}};
                        next_wrap_s = 1'b1;
                    end else begin
                        next_q_s = inc_s[WIDTH-1:0];
                    end
                end
                MODE_DOWN: begin
                    if (q_r == {WIDTH{1'b0}}) begin
                        next_q_s    = MAX_Q;
                        next_wrap_s = 1'b1;
                    end else if (q_ext_s >= MOD_W) begin
                        // Out-of-range value is pulled back into range without a wrap.
                        next_q_s = MAX_Q;
                    end else begin
                        next_q_s = dec_s[WIDTH-1:0];
                    end
                end
                MODE_LOAD: begin
                    if (ld_ext_s < MOD_W) begin
                        next_q_s = load_data;
                    end else begin
                        next_q_s = MAX_Q;
                    end
                end
                default: begin
                    next_q_s = q_r;
                end
            endcase
        end else begin
            next_q_s = q_r;
        end
    end

    // State and wrap pulse registers with asynchronous reset.
    always_ff @(posedge input_clock1_c_1 or posedge input_reset_2) begin
        if (input_reset_2) begin
            q_r    <= RESET_Q;
            wrap_r <= 1'b0;
        end else begin
            q_r    <= next_q_s;
            wrap_r <= next_wrap_s;
        end
    end

    // Terminal count looks at the current mode, not the enable.
    always_comb begin
        terminal = ((mode == MODE_UP)   && (q_ext_s == MAX_W)) ||
                   ((mode == MODE_DOWN) && (q_r == {WIDTH{1'b0}}));
    end

    assign q          = q_r;
    assign q_n        = ~q_r;
    assign wrap_pulse = wrap_r;

endmodule

// File: tb/tb_jk_counter_register.sv
// Self-checking bench for jk_counter_register (WIDTH=4, MODULUS=10, RESET_VALUE=5).
// Directed scenarios followed by randomized traffic, all compared against an
// integer reference model of the counter's rules.
module tb_jk_counter_register;

    localparam int W   = 4;
    localparam int MOD = 10;
    localparam int RV  = 5;

    logic         clk;
    logic         rst;
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] j;
    logic [W-1:0] k;
    logic [W-1:0] load_data;
    logic [W-1:0] q;
    logic [W-1:0] q_n;
    logic         terminal;
    logic         wrap_pulse;

    int checks;
    int errors;
    int m_q;     // model state
    int m_wrap;  // model wrap pulse

    jk_counter_register #(
        .WIDTH       (W),
        .MODULUS     (64'd10),
        .RESET_VALUE (64'd5)
    ) dut (
        .input_clock1_c_1 (clk),
        .input_reset_2    (rst),
        .en               (en),
        .mode             (mode),
        .j                (j),
        .k                (k),
        .load_data        (load_data),
        .q                (q),
        .q_n              (q_n),
        .terminal         (terminal),
        .wrap_pulse       (wrap_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".q"}, 32'(q), 32'(m_q));
        check({tag, ".q_n"}, 32'(q_n), 32'((~m_q) & 15));
        check({tag, ".wrap"}, 32'(wrap_pulse), 32'(m_wrap));
    endtask

    // Reference: the counter rules expressed with plain integer arithmetic.
    task automatic model_step(input int e, input int md, input int jj, input int kk, input int ld);
        int nq;
        int nw;
        nq = m_q;
        nw = 0;
        if (e != 0) begin
            if (md == 0) begin
                // JK characteristic equation Q+ = J&~Q | ~K&Q, bitwise.
                nq = ((jj & ~m_q) | (~kk & m_q)) & 15;
            end else if (md == 1) begin
                if (m_q >= MOD - 1) begin nq = 0; nw = 1; end
                else nq = m_q + 1;
            end else if (md == 2) begin
                if (m_q == 0) begin nq = MOD - 1; nw = 1; end
                else if (m_q >= MOD) nq = MOD - 1;
                else nq = m_q - 1;
            end else begin
                nq = (ld < MOD) ? ld : MOD - 1;
            end
        end
        m_q    = nq;
        m_wrap = nw;
    endtask

    // One clock: drive inputs, check terminal, clock, check registered outputs.
    task automatic cycle(input string tag, input logic e, input logic [1:0] md,
                         input logic [W-1:0] jj, input logic [W-1:0] kk,
                         input logic [W-1:0] ld);
        int exp_term;
        en        = e;
        mode      = md;
        j         = jj;
        k         = kk;
        load_data = ld;
        #1;
        exp_term = ((md == 2'd1 && m_q == MOD - 1) || (md == 2'd2 && m_q == 0)) ? 1 : 0;
        check({tag, ".terminal"}, 32'(terminal), 32'(exp_term));
        model_step(int'(e), int'(md), int'(jj), int'(kk), int'(ld));
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    // Reset asserted between edges must take effect without a clock.
    task automatic async_reset(input string tag);
        rst = 1'b1;
        #1;
        m_q    = RV;
        m_wrap = 0;
        check_outputs(tag);
        rst = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        en        = 1'b0;
        mode      = 2'd0;
        j         = '0;
        k         = '0;
        load_data = '0;
        m_q       = RV;
        m_wrap    = 0;
        #12;
        check_outputs("reset_init");
        @(negedge clk);
        rst = 1'b0;

        // Move away from reset value, then reset mid-cycle.
        cycle("pre_up0", 1'b1, 2'd1, 4'd0, 4'd0, 4'd0);
        cycle("pre_up1", 1'b1, 2'd1, 4'd0, 4'd0, 4'd0);
        #2;
        async_reset("reset_mid");
        cycle("post_rst", 1'b1, 2'd1, 4'd0, 4'd0, 4'd0);

        // Per-bit JK from 0110 with j=1100, k=1010.
        cycle("jk_load", 1'b1, 2'd3, 4'd0, 4'd0, 4'b0110);
        cycle("jk_bits", 1'b1, 2'd0, 4'b1100, 4'b1010, 4'd0);

        // Up wrap 8 -> 9 -> 0 -> 1.
        cycle("up_load", 1'b1, 2'd3, 4'd0, 4'd0, 4'd8);
        for (int i = 0; i < 3; i++) cycle("up_wrap", 1'b1, 2'd1, 4'd0, 4'd0, 4'd0);

        // Down wrap with enable gaps: 1 -> 0, hold, hold, -> 9.
        cycle("dn_load", 1'b1, 2'd3, 4'd0, 4'd0, 4'd1);
        cycle("dn_0", 1'b1, 2'd2, 4'd0, 4'd0, 4'd0);
        cycle("dn_hold0", 1'b0, 2'd2, 4'd0, 4'd0, 4'd0);
        cycle("dn_hold1", 1'b0, 2'd2, 4'd0, 4'd0, 4'd0);
        cycle("dn_wrap", 1'b1, 2'd2, 4'd0, 4'd0, 4'd0);
        cycle("dn_after", 1'b1, 2'd2, 4'd0, 4'd0, 4'd0);

        // Load clamp.
        cycle("ld_clamp", 1'b1, 2'd3, 4'd0, 4'd0, 4'd12);
        cycle("ld_3", 1'b1, 2'd3, 4'd0, 4'd0, 4'd3);
        cycle("ld_15", 1'b1, 2'd3, 4'd0, 4'd0, 4'd15);

        // Out-of-range recovery through JK.
        cycle("oor_set_a", 1'b1, 2'd0, 4'hF, 4'h0, 4'd0);
        cycle("oor_up", 1'b1, 2'd1, 4'd0, 4'd0, 4'd0);
        cycle("oor_set_b", 1'b1, 2'd0, 4'hF, 4'h0, 4'd0);
        cycle("oor_down", 1'b1, 2'd2, 4'd0, 4'd0, 4'd0);
        cycle("oor_set_c", 1'b1, 2'd0, 4'hB, 4'h0, 4'd0);
        cycle("oor_down2", 1'b1, 2'd2, 4'd0, 4'd0, 4'd0);

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 400; i++) begin
            cycle("rand",
                  ($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0,
                  2'($urandom_range(0, 3)),
                  4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)));
            if ($urandom_range(0, 49) == 0) begin
                #2;
                async_reset("rand_rst");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
